// File: rtl/sd_emmc_pkg.sv
// Shared types and defaults for the SD/eMMC command path.
package sd_emmc_pkg;

  // Default command word: 6-bit index plus 32-bit argument, framed to 40 bits.
  localparam int CMD_W_DEF = 40;
  // Default per-command setting: the expected response type.
  localparam int SET_W_DEF = 2;

  // Command arbiter sequencing: grant, kick the serializer, wait, hand back.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Response-type encodings carried in the setting field.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,  // no response expected (CMD0, broadcast)
    RSP_R1   = 2'd1,  // 48-bit short response
    RSP_R2   = 2'd2,  // 136-bit long response (CID/CSD)
    RSP_R1B  = 2'd3   // short response followed by busy on DAT0
  } rsp_type_e;

  // Width of a counter that must hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sd_emmc_rr_pick.sv
// Rotating priority encoder: the first set request at or above ptr wins,
// wrapping from the top channel back to channel 0. With ptr held at 0 it
// degenerates to a plain lowest-index-wins priority encoder.
module sd_emmc_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  // One extra bit so ptr + offset can exceed NUM_CH-1 before folding back.
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;

  // Scan NUM_CH positions starting at ptr; the first hit is latched by valid.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_CH)) begin
        sum = sum - (IDX_W+1)'(NUM_CH);
      end
      pos = sum[IDX_W-1:0];
      if (!valid && req[pos]) begin
        valid = 1'b1;
        idx   = pos;
        gnt   = NUM_CH'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/sd_emmc_cmd_arbiter.sv
// N-channel command arbiter in front of the CMD-line serializer. Grants one
// requester at a time (round-robin or fixed priority), latches its command
// and setting, pulses start_xfr_o, then waits for cmd_done_i or a watchdog
// timeout before returning a done/error pulse to the granted channel.
module sd_emmc_cmd_arbiter
  import sd_emmc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CMD_W  = CMD_W_DEF,
  parameter int SET_W  = SET_W_DEF,
  parameter int RR_EN  = 1,
  parameter int TO_CYC = 65535
) (
  input  logic                    sd_clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH*CMD_W-1:0] cmd_i,
  input  logic [NUM_CH*SET_W-1:0] setting_i,
  input  logic                    cmd_done_i,
  output logic [NUM_CH-1:0]       gnt_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       err_o,
  output logic [CMD_W-1:0]        cmd_o,
  output logic [SET_W-1:0]        setting_o,
  output logic                    start_xfr_o,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = cnt_width(TO_CYC);
  // Counter value seen in the last WAIT cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] TO_LAST = (TO_CYC > 0) ? CNT_W'(TO_CYC - 1) : '0;

  arb_state_e        state;
  arb_state_e        next_state;

  logic [NUM_CH-1:0] gnt_q;      // one-hot owner of the current command
  logic [IDX_W-1:0]  win_idx;    // same owner as an index, for the pointer
  logic [IDX_W-1:0]  rr_ptr;     // channel scanned first at the next grant

  logic [IDX_W-1:0]  pick_ptr;
  logic [NUM_CH-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [CMD_W-1:0]  pick_cmd;
  logic [SET_W-1:0]  pick_set;

  logic [CNT_W-1:0]  wd_cnt;
  logic              to_hit;
  logic              timed_out;

  // Fixed-priority mode simply never rotates the scan start.
  assign pick_ptr = (RR_EN != 0) ? rr_ptr : '0;

  sd_emmc_rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req    (req_i),
    .ptr    (pick_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Watchdog expiry; a disabled watchdog can never fire.
  assign to_hit = (TO_CYC != 0) && (wd_cnt == TO_LAST);

  // Steer the winner's command and setting out of the packed buses.
  always_comb begin
    pick_cmd = '0;
    pick_set = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      pick_cmd = pick_cmd | ({CMD_W{pick_gnt[k]}} & cmd_i[k*CMD_W +: CMD_W]);
      pick_set = pick_set | ({SET_W{pick_gnt[k]}} & setting_i[k*SET_W +: SET_W]);
    end
  end

  // State register; reset aborts whatever command is in flight.
  always_ff @(posedge sd_clk) begin
    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    next_state  = state;
    start_xfr_o = 1'b0;
    busy_o      = 1'b1;
    gnt_o       = '0;
    done_o      = '0;
    err_o       = '0;
    case (state)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (pick_valid) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // cmd_done_i is deliberately ignored here: the serializer has not
        // been started yet, so any pulse belongs to nobody.
        start_xfr_o = 1'b1;
        gnt_o       = gnt_q;
        next_state  = ST_WAIT;
      end
      ST_WAIT: begin
        gnt_o = gnt_q;
        if (cmd_done_i || to_hit) begin
          next_state = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        done_o     = gnt_q;
        err_o      = timed_out ? gnt_q : '0;
        next_state = ST_IDLE;
      end
      default: begin
        busy_o     = 1'b0;
        next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the winner and its command at the grant edge; held until the
  // next grant so the serializer can keep reading them.
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      gnt_q     <= '0;
      win_idx   <= '0;
      cmd_o     <= '0;
      setting_o <= '0;
    end else if (state == ST_IDLE && pick_valid) begin
      gnt_q     <= pick_gnt;
      win_idx   <= pick_idx;
      cmd_o     <= pick_cmd;
      setting_o <= pick_set;
    end
  end

  // Advance the round-robin pointer past the channel just serviced.
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == ST_RELEASE) begin
      rr_ptr <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // Watchdog: cleared while issuing, counts WAIT cycles, and remembers
  // whether WAIT ended by expiry; a same-cycle done overrides the expiry.
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          wd_cnt    <= '0;
          timed_out <= 1'b0;
        end
        ST_WAIT: begin
          wd_cnt    <= wd_cnt + CNT_W'(1);
          timed_out <= !cmd_done_i && to_hit;
        end
        default: begin
          wd_cnt    <= wd_cnt;
          timed_out <= timed_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_emmc_cmd_arbiter.sv
// Bench for sd_emmc_cmd_arbiter: two instances share one stimulus stream,
// one round-robin with a 16-cycle watchdog, one fixed-priority with an
// 8-cycle watchdog. A transaction-level model predicts both every cycle.
module tb_sd_emmc_cmd_arbiter;
  import sd_emmc_pkg::*;

  localparam int N  = 4;
  localparam int CW = 40;
  localparam int SW = 2;

  logic              sd_clk = 1'b0;
  logic              rst    = 1'b1;
  logic [N-1:0]      req    = '0;
  logic [N*CW-1:0]   cmd_in = '0;
  logic [N*SW-1:0]   set_in = '0;
  logic              cmd_done = 1'b0;

  logic [N-1:0]  gnt_d   [2];
  logic [N-1:0]  done_d  [2];
  logic [N-1:0]  err_d   [2];
  logic [CW-1:0] cmd_d   [2];
  logic [SW-1:0] set_d   [2];
  logic          start_d [2];
  logic          busy_d  [2];

  int checks = 0;
  int errors = 0;

  always #5 sd_clk = ~sd_clk;

  sd_emmc_cmd_arbiter #(.NUM_CH(N), .CMD_W(CW), .SET_W(SW), .RR_EN(1), .TO_CYC(16)) u_rr (
    .sd_clk(sd_clk), .rst(rst), .req_i(req), .cmd_i(cmd_in), .setting_i(set_in),
    .cmd_done_i(cmd_done), .gnt_o(gnt_d[0]), .done_o(done_d[0]), .err_o(err_d[0]),
    .cmd_o(cmd_d[0]), .setting_o(set_d[0]), .start_xfr_o(start_d[0]), .busy_o(busy_d[0]));

  sd_emmc_cmd_arbiter #(.NUM_CH(N), .CMD_W(CW), .SET_W(SW), .RR_EN(0), .TO_CYC(8)) u_fp (
    .sd_clk(sd_clk), .rst(rst), .req_i(req), .cmd_i(cmd_in), .setting_i(set_in),
    .cmd_done_i(cmd_done), .gnt_o(gnt_d[1]), .done_o(done_d[1]), .err_o(err_d[1]),
    .cmd_o(cmd_d[1]), .setting_o(set_d[1]), .start_xfr_o(start_d[1]), .busy_o(busy_d[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // busy: a command owns the line; ph 0 is the start cycle, ph w>0 is the
  // w-th cycle spent waiting; rel marks the one-cycle hand-back.
  typedef struct {
    bit          busy;
    int          ph;
    bit          rel;
    bit          err;
    int          win;
    int          ptr;
    logic [CW-1:0] cmd;
    logic [SW-1:0] set;
  } mdl_t;

  mdl_t m [2];

  function automatic int limit_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  function automatic bit rr_of(input int k);
    return (k == 0);
  endfunction

  task automatic model_step(input int k);
    int  base;
    bit  found;
    if (rst) begin
      m[k].busy = 0; m[k].rel = 0; m[k].err = 0; m[k].ph = 0;
      m[k].win  = 0; m[k].ptr = 0; m[k].cmd = '0; m[k].set = '0;
    end else if (m[k].rel) begin
      m[k].rel = 0;
      m[k].err = 0;
      m[k].ptr = (m[k].win + 1) % N;
    end else if (m[k].busy) begin
      if (m[k].ph == 0) m[k].ph = 1;
      else if (cmd_done) begin m[k].busy = 0; m[k].rel = 1; m[k].err = 0; end
      else if (m[k].ph == limit_of(k)) begin m[k].busy = 0; m[k].rel = 1; m[k].err = 1; end
      else m[k].ph++;
    end else if (req != '0) begin
      base  = rr_of(k) ? m[k].ptr : 0;
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req[(base + i) % N]) begin
          found    = 1;
          m[k].win = (base + i) % N;
        end
      end
      m[k].cmd  = cmd_in[m[k].win*CW +: CW];
      m[k].set  = set_in[m[k].win*SW +: SW];
      m[k].busy = 1;
      m[k].ph   = 0;
    end
  endtask

  always @(posedge sd_clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Compare both instances against the model on every falling edge.
  always @(negedge sd_clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [N-1:0] oh;
      string        tag;
      oh  = N'(1) << m[k].win;
      tag = (k == 0) ? "rr" : "fp";
      check($sformatf("%s.gnt", tag),   gnt_d[k],   m[k].busy ? oh : '0);
      check($sformatf("%s.start", tag), start_d[k], m[k].busy && m[k].ph == 0);
      check($sformatf("%s.busy", tag),  busy_d[k],  m[k].busy || m[k].rel);
      check($sformatf("%s.done", tag),  done_d[k],  m[k].rel ? oh : '0);
      check($sformatf("%s.err", tag),   err_d[k],   (m[k].rel && m[k].err) ? oh : '0);
      check($sformatf("%s.cmd", tag),   cmd_d[k],   m[k].cmd);
      check($sformatf("%s.set", tag),   set_d[k],   m[k].set);
    end
  end

  // ---------------- directed helpers ----------------
  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < N; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  // Called on an IDLE falling edge with req already driven. Returns the
  // winners seen in the start cycle, the number of wait cycles the rr
  // instance spent, and whether each instance flagged an error on release.
  task automatic serve(input int done_at, input bit drop, output int win_a, output int win_b,
                       output int waits, output bit ea, output bit eb);
    bit got;
    got = 0; waits = 0; ea = 0; eb = 0;
    @(negedge sd_clk);
    win_a = oh_idx(gnt_d[0]);
    win_b = oh_idx(gnt_d[1]);
    if (drop) req = '0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge sd_clk);
      cmd_done = 1'b0;
      if (done_d[1] != '0) eb = (err_d[1] != '0);
      if (done_d[0] != '0) begin
        ea  = (err_d[0] != '0);
        got = 1;
      end else begin
        waits++;
        if (waits == done_at) cmd_done = 1'b1;
      end
    end
    check("serve.release_seen", got, 1);
    @(negedge sd_clk);
  endtask

  task automatic randomize_cmds();
    for (int w = 0; w < N*CW/32; w++) cmd_in[w*32 +: 32] = $urandom;
    set_in = 8'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int wa, wb, wt;
    bit ea, eb;
    int ord_a [5];
    int ord_b [5];
    int exp_rr [5] = '{0, 1, 2, 3, 0};

    randomize_cmds();
    rst = 1'b1;
    repeat (2) @(negedge sd_clk);
    check("reset.gnt",   gnt_d[0],   4'b0000);
    check("reset.busy",  busy_d[0],  1'b0);
    check("reset.start", start_d[0], 1'b0);
    check("reset.cmd",   cmd_d[0],   40'h0);
    rst = 1'b0;

    // Single request on channel 2, done 10 cycles after the start pulse.
    cmd_in[2*CW +: CW] = 40'h11_0000_0200;
    set_in[2*SW +: SW] = RSP_R1B;
    req = 4'b0100;
    @(negedge sd_clk);
    check("single.gnt",   gnt_d[0],   4'b0100);
    check("single.start", start_d[0], 1'b1);
    check("single.cmd",   cmd_d[0],   40'h11_0000_0200);
    check("single.set",   set_d[0],   2'd3);
    req = '0;
    @(negedge sd_clk);
    check("single.start_once", start_d[0], 1'b0);
    check("single.gnt_hold",   gnt_d[0],   4'b0100);
    repeat (9) @(negedge sd_clk);
    cmd_done = 1'b1;
    @(negedge sd_clk);
    cmd_done = 1'b0;
    check("single.done", done_d[0], 4'b0100);
    check("single.err",  err_d[0],  4'b0000);
    check("single.gnt_rel", gnt_d[0], 4'b0000);
    @(negedge sd_clk);
    check("single.done_once", done_d[0], 4'b0000);
    check("single.idle", busy_d[0], 1'b0);
    check("single.cmd_held", cmd_d[0], 40'h11_0000_0200);

    // Service channel 3 so the rr pointer wraps to 0, then hold all requests.
    req = 4'b1000;
    serve(3, 1, wa, wb, wt, ea, eb);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(3, 0, wa, wb, wt, ea, eb);
      ord_a[i] = wa;
      ord_b[i] = wb;
    end
    req = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr.order%0d", i), ord_a[i], exp_rr[i]);
      check($sformatf("fp.order%0d", i), ord_b[i], 0);
    end

    // Watchdog expiry with no completion, then a normal command.
    randomize_cmds();
    req = 4'b0010;
    serve(0, 1, wa, wb, wt, ea, eb);
    check("timeout.win",   wa, 1);
    check("timeout.waits", wt, 16);
    check("timeout.err",   ea, 1);
    check("timeout.fp_err", eb, 1);
    req = 4'b0001;
    serve(4, 1, wa, wb, wt, ea, eb);
    check("after_to.win",   wa, 0);
    check("after_to.waits", wt, 4);
    check("after_to.err",   ea, 0);

    // Done arrives in the 8th wait cycle: the 8-cycle watchdog must yield.
    req = 4'b0100;
    serve(8, 1, wa, wb, wt, ea, eb);
    check("tie.waits",  wt, 8);
    check("tie.fp_err", eb, 0);
    check("tie.rr_err", ea, 0);

    // Pointer sits at 3 after channel 2: channel 0 wins over channel 1.
    req = 4'b0011;
    serve(2, 1, wa, wb, wt, ea, eb);
    check("wrap.rr_win", wa, 0);
    check("wrap.fp_win", wb, 0);

    // Channel 1 moves the pointer to 2; reset mid-wait must put it back to 0.
    req = 4'b0010;
    serve(2, 1, wa, wb, wt, ea, eb);
    req = 4'b0100;
    @(negedge sd_clk);
    req = '0;
    repeat (2) @(negedge sd_clk);
    rst = 1'b1;
    @(negedge sd_clk);
    check("rst.gnt",   gnt_d[0],   4'b0000);
    check("rst.busy",  busy_d[0],  1'b0);
    check("rst.start", start_d[0], 1'b0);
    check("rst.done",  done_d[0],  4'b0000);
    rst = 1'b0;
    req = 4'b1010;
    serve(3, 1, wa, wb, wt, ea, eb);
    check("rst.ptr_cleared", wa, 1);

    // Randomised traffic, including occasional resets, checked by the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge sd_clk);
      rst      = ($urandom_range(0, 199) == 0);
      req      = 4'($urandom) & 4'($urandom);
      cmd_done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) randomize_cmds();
    end
    @(negedge sd_clk);
    rst = 1'b0; req = '0; cmd_done = 1'b0;
    repeat (4) @(negedge sd_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
